// File: rtl/dp_ram_fifo_ctrl_pkg.sv
// dp_ram_fifo_ctrl_pkg: shared defaults and derived-size helpers for the FIFO controller
package dp_ram_fifo_ctrl_pkg;
    localparam int DEF_DATA_WIDTH    = 8;
    localparam int DEF_ADDR_WIDTH    = 8;
    localparam int DEF_DEPTH         = 2 ** DEF_ADDR_WIDTH;
    localparam int DEF_AFULL_THRESH  = DEF_DEPTH - 4;
    localparam int DEF_AEMPTY_THRESH = 4;

    function automatic int depth_of(input int aw);
        return 2 ** aw;
    endfunction

    function automatic int level_width_of(input int aw);
        return aw + 1;
    endfunction
endpackage

// File: rtl/dp_ram_fifo_ctrl_flag_gen.sv
// dp_ram_fifo_ctrl_flag_gen: registered FULL/EMPTY/AFULL/AEMPTY derived from next-cycle occupancy
module dp_ram_fifo_ctrl_flag_gen
    import dp_ram_fifo_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int AFULL_THRESH  = DEF_AFULL_THRESH,
    parameter int AEMPTY_THRESH = DEF_AEMPTY_THRESH
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [level_width_of(ADDR_WIDTH)-1:0] level_d_i,
    output logic                                  full_o,
    output logic                                  empty_o,
    output logic                                  afull_o,
    output logic                                  aempty_o
);
    localparam int LW = level_width_of(ADDR_WIDTH);
    localparam logic [LW-1:0] DEPTH_L = LW'(depth_of(ADDR_WIDTH));
    localparam logic [LW-1:0] AF_L    = LW'(AFULL_THRESH);
    localparam logic [LW-1:0] AE_L    = LW'(AEMPTY_THRESH);

    logic full_q, empty_q, afull_q, aempty_q;
    logic full_d, empty_d, afull_d, aempty_d;

    always_comb begin
        full_d   = level_d_i == DEPTH_L;
        empty_d  = level_d_i == '0;
        afull_d  = level_d_i >= AF_L;
        aempty_d = level_d_i <= AE_L;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
        end
    end

    assign full_o   = full_q;
    assign empty_o  = empty_q;
    assign afull_o  = afull_q;
    assign aempty_o = aempty_q;
endmodule

// File: rtl/dp_ram_fifo_ctrl.sv
// dp_ram_fifo_ctrl: FIFO controller sequencing an external dual-port RAM (write port A, read port B)
// Read data is the RAM output passed through, qualified by a strobe one cycle after the accept.
module dp_ram_fifo_ctrl
    import dp_ram_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int AFULL_THRESH  = DEF_AFULL_THRESH,
    parameter int AEMPTY_THRESH = DEF_AEMPTY_THRESH
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  wr_en_i,
    input  logic [DATA_WIDTH-1:0]                 wr_data_i,
    input  logic                                  rd_en_i,
    output logic [DATA_WIDTH-1:0]                 rd_data_o,
    output logic                                  rd_valid_o,
    input  logic                                  flush_i,
    output logic                                  full_o,
    output logic                                  empty_o,
    output logic                                  afull_o,
    output logic                                  aempty_o,
    output logic [level_width_of(ADDR_WIDTH)-1:0] level_o,
    output logic                                  overflow_o,
    output logic                                  underflow_o,
    output logic [ADDR_WIDTH-1:0]                 ram_waddr_o,
    output logic [DATA_WIDTH-1:0]                 ram_wdata_o,
    output logic                                  ram_we_o,
    output logic [ADDR_WIDTH-1:0]                 ram_raddr_o,
    input  logic [DATA_WIDTH-1:0]                 ram_rdata_i
);
    localparam int LW = level_width_of(ADDR_WIDTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  overflow_q, overflow_d, underflow_q, underflow_d;
    logic                  full, empty, wr_acc, rd_acc;

    // Accepts use the registered flags, so a full FIFO refuses a write even when a read frees space
    always_comb begin
        wr_acc      = wr_en_i & ~full & ~flush_i & ~rst_i;
        rd_acc      = rd_en_i & ~empty & ~flush_i & ~rst_i;
        wr_ptr_d    = flush_i ? '0 : wr_ptr_q + ADDR_WIDTH'(wr_acc);
        rd_ptr_d    = flush_i ? '0 : rd_ptr_q + ADDR_WIDTH'(rd_acc);
        level_d     = flush_i ? '0 : level_q + LW'(wr_acc) - LW'(rd_acc);
        rd_valid_d  = rd_acc;
        overflow_d  = ~flush_i & (overflow_q | (wr_en_i & full));
        underflow_d = ~flush_i & (underflow_q | (rd_en_i & empty));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    dp_ram_fifo_ctrl_flag_gen #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .AFULL_THRESH  (AFULL_THRESH),
        .AEMPTY_THRESH (AEMPTY_THRESH)
    ) u_fifo_flag_gen (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .level_d_i (level_d),
        .full_o    (full),
        .empty_o   (empty),
        .afull_o   (afull_o),
        .aempty_o  (aempty_o)
    );

    assign full_o      = full;
    assign empty_o     = empty;
    assign level_o     = level_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;
    assign ram_we_o    = wr_acc;
    assign ram_waddr_o = wr_ptr_q;
    assign ram_wdata_o = wr_data_i;
    assign ram_raddr_o = rd_ptr_q;
    assign rd_data_o   = ram_rdata_i;
    assign rd_valid_o  = rd_valid_q;
endmodule

// File: doc/dp_ram_fifo_ctrl.md
Name: dp_ram_fifo_ctrl

Overview:
Single-clock FIFO controller that sequences an external dual-port RAM. Port A is write-only from the controller's view; port B is read-only. The controller owns the write pointer, read pointer, occupancy count and status flags. It compensates for the RAM's one-cycle registered-address read latency and provides a strobed read-data interface. It sits between a producer/consumer pair and one RAM instance of depth 2**ADDR_WIDTH.

Parameters:
DATA_WIDTH, 8, word width; must match the RAM.
ADDR_WIDTH, 8, RAM address width; FIFO depth = 2**ADDR_WIDTH.
AFULL_THRESH, 2**ADDR_WIDTH-4, AFULL asserts when LEVEL >= this value.
AEMPTY_THRESH, 4, AEMPTY asserts when LEVEL <= this value.

Ports:
CLK  in  1  single clock; also drives both RAM port clocks.
RST  in  1  synchronous, active-high reset.
WR_EN  in  1  producer write request.
WR_DATA  in  DATA_WIDTH  producer data.
RD_EN  in  1  consumer read request.
RD_DATA  out  DATA_WIDTH  read data; valid only when RD_VALID=1.
RD_VALID  out  1  one-cycle strobe marking RD_DATA valid.
FLUSH  in  1  synchronous clear of FIFO contents.
FULL  out  1  LEVEL == depth.
EMPTY  out  1  LEVEL == 0.
AFULL  out  1  almost-full flag.
AEMPTY  out  1  almost-empty flag.
LEVEL  out  ADDR_WIDTH+1  current occupancy.
OVERFLOW  out  1  sticky: a write was attempted while FULL.
UNDERFLOW  out  1  sticky: a read was attempted while EMPTY.
RAM_WADDR  out  ADDR_WIDTH  to RAM port A address.
RAM_WDATA  out  DATA_WIDTH  to RAM port A data in.
RAM_WE  out  1  to RAM port A write enable.
RAM_RADDR  out  ADDR_WIDTH  to RAM port B address.
RAM_RDATA  in  DATA_WIDTH  from RAM port B data out.

Behaviour:
- Clocking and reset: one clock, CLK. RST is synchronous and active-high.
- Reset values (while RST=1 and after): wr_ptr=0, rd_ptr=0, LEVEL=0, EMPTY=1, FULL=0, AEMPTY=1, AFULL=0, RD_VALID=0, OVERFLOW=0, UNDERFLOW=0. RAM_WE is forced to 0 during RST. RD_DATA is don't-care.
- Accept rules, evaluated on registered flags:
  - wr_acc = WR_EN & ~FULL & ~FLUSH & ~RST
  - rd_acc = RD_EN & ~EMPTY & ~FLUSH & ~RST
- Write path (combinational to the RAM): RAM_WE = wr_acc, RAM_WADDR = wr_ptr, RAM_WDATA = WR_DATA. On wr_acc, wr_ptr increments modulo depth (natural wrap).
- Read path: RAM_RADDR = rd_ptr. On rd_acc, rd_ptr increments modulo depth. RD_VALID is registered: it equals rd_acc delayed by one cycle. RD_DATA = RAM_RDATA is passed through. Read latency is 1 cycle from RD_EN accepted to RD_VALID.
- LEVEL update:
  - +1 on wr_acc only.
  - -1 on rd_acc only.
  - Unchanged when both or neither are accepted.
  - Flags are registered and derived from next-LEVEL, so they are valid in the same cycle as LEVEL.
- Full with simultaneous WR_EN and RD_EN: the read is accepted and the write is rejected (no write-through on full). LEVEL drops to depth-1 and OVERFLOW is set.
- Empty with simultaneous WR_EN and RD_EN: the write is accepted and the read is rejected. UNDERFLOW is set. The written word becomes readable the next cycle.
- Read-after-write hazard: none. A word written at edge n is readable by RD_EN from cycle n+1. The RAM's read is combinational on its registered address, so a read at edge n+1 sees data written at edge n.
- FLUSH:
  - Takes priority over WR_EN and RD_EN.
  - Next cycle: pointers=0, LEVEL=0, EMPTY=1, AEMPTY=1, FULL=0, AFULL=0, RD_VALID=0, OVERFLOW=0, UNDERFLOW=0.
  - A RD_VALID already scheduled for the FLUSH cycle still fires (it comes from the previous accept).
  - RAM contents are not cleared.
- Sticky flags: OVERFLOW sets on WR_EN & FULL; UNDERFLOW sets on RD_EN & EMPTY. They clear only on RST or FLUSH.
- Reset mid-operation: same as the reset values. Any in-flight RD_VALID is suppressed.
- Width rules: LEVEL is ADDR_WIDTH+1 bits, so the full count of depth is representable. Pointers are ADDR_WIDTH bits and wrap with no special case.

Decomposition:
- Shared package: DEPTH = 2**ADDR_WIDTH and LEVEL_WIDTH = ADDR_WIDTH+1 as derived constants, plus the default thresholds.
- Sub-module: one natural sub-module, fifo_flag_gen. It takes next-LEVEL and produces registered FULL, EMPTY, AFULL and AEMPTY.
- Top level: instantiates the RAM externally. The controller does not instantiate the RAM, so it can share one RAM type across bench and system.

Test Plan:
Bench parameters: ADDR_WIDTH=4 (depth 16), AFULL_THRESH=12, AEMPTY_THRESH=4.
1. Reset, then write 0x11..0x20 (16 words) -> AEMPTY drops when LEVEL=5. AFULL rises at LEVEL=12. FULL=1 at LEVEL=16. A 17th write sets OVERFLOW and leaves RAM_WE=0.
2. Fill 16, then read 16 -> RD_VALID one cycle after each accepted RD_EN. RD_DATA follows 0x11..0x20 in order. EMPTY=1 at the end. A further RD_EN sets UNDERFLOW.
3. Run 40 writes and 40 reads interleaved at LEVEL≈8 -> pointers wrap twice. Data order is preserved and LEVEL holds steady on simultaneous accepts.
4. From empty, drive WR_EN and RD_EN together with 0xAA -> write accepted, UNDERFLOW=1, LEVEL=1. Next cycle RD_EN returns 0xAA with RD_VALID.
5. From full, drive WR_EN and RD_EN together -> the oldest word is returned, LEVEL=15, OVERFLOW=1, and the write data is dropped.
6. At LEVEL=9, assert FLUSH with WR_EN=1 -> next cycle LEVEL=0, EMPTY=1, sticky flags clear, no RAM write. Assert RST at LEVEL=5 with a read pending -> RD_VALID=0 the next cycle and all reset values hold.
